// File: rtl/rv_decode_pkg.sv
// Shared types and opcode constants for the RISC-V decode stage.
// Consumers build their XLEN-wide bundle around dec_bundle_t.
package rv_decode_pkg;

  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_U  = 3'd1,
    FMT_S  = 3'd2,
    FMT_R  = 3'd3,
    FMT_SB = 3'd4,
    FMT_UJ = 3'd5
  } fmt_e;

  // Occupancy of the stage: main register only, or main plus skid entry.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_BOTH  = 2'd2
  } occ_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_IMM_32 = 7'h1B;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_OP_32  = 7'h3B;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    fmt_e       fmt;
    logic       rd_wr;
    logic       rs1_used;
    logic       rs2_used;
    logic       illegal;
  } dec_bundle_t;

  function automatic fmt_e opcode_fmt(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_AUIPC, OP_LUI:  f = FMT_U;
      OP_STORE:          f = FMT_S;
      OP_OP, OP_OP_32:   f = FMT_R;
      OP_BRANCH:         f = FMT_SB;
      OP_JAL:            f = FMT_UJ;
      default:           f = FMT_I;
    endcase
    return f;
  endfunction

  function automatic logic opcode_known(input logic [6:0] op);
    logic k;
    case (op)
      OP_LOAD, OP_IMM, OP_AUIPC, OP_IMM_32, OP_STORE, OP_OP,
      OP_LUI, OP_OP_32, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: k = 1'b1;
      default: k = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/rv_decode_if.sv
// Fetch-to-decode and decode-to-issue signals of the decode stage.
// Handshake: a transfer happens on a rising edge where valid && ready; valid
// never depends on ready, and payload holds steady while valid && !ready.
interface rv_decode_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_imm;
  logic            out_rd_wr;
  logic            out_rs1_used;
  logic            out_rs2_used;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_fmt, out_imm, out_rd_wr, out_rs1_used,
           out_rs2_used, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_fmt, out_imm, out_rd_wr, out_rs1_used,
           out_rs2_used, out_illegal
  );
endinterface

// File: rtl/rv_imm_gen.sv
// Immediate generator: builds the sign-extended immediate for a given format.
// Only instr[31:7] carries immediate bits, so the opcode is not an input.
module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:  imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_SB: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
      FMT_U:  imm32 = {instr[31:12], 12'h000};
      FMT_UJ: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Every 32-bit form already carries its sign in bit 31; widen for RV64.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I/RV64I (+optional M) decode stage between fetch and issue,
// with an optional two-entry skid buffer for a fully registered in_ready.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int M_EXT = 0,
  parameter int SKID  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  rv_decode_if.slave  bus,
  output occ_e        dbg_state
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    dec_bundle_t     dec;
  } entry_t;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  fmt_e            fmt;
  logic [XLEN-1:0] imm;
  logic            funct7_ok;
  logic            illegal;
  entry_t          dec_entry;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign fmt    = opcode_fmt(opcode);

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr[31:7]),
    .fmt   (fmt),
    .imm   (imm)
  );

  assign funct7_ok = (funct7 == 7'h00) || (funct7 == 7'h20) ||
                     ((M_EXT != 0) && (funct7 == 7'h01));

  assign illegal = (instr[1:0] != 2'b11) || !opcode_known(opcode) ||
                   ((fmt == FMT_R) && !funct7_ok) ||
                   ((XLEN == 32) && ((opcode == OP_IMM_32) || (opcode == OP_OP_32))) ||
                   ((opcode == OP_JALR) && (funct3 != 3'd0));

  // Illegal bundles still travel downstream but must not touch the register file.
  always_comb begin
    dec_entry              = '0;
    dec_entry.pc           = bus.in_pc;
    dec_entry.imm          = imm;
    dec_entry.dec.opcode   = opcode;
    dec_entry.dec.rd       = rd;
    dec_entry.dec.rs1      = instr[19:15];
    dec_entry.dec.rs2      = instr[24:20];
    dec_entry.dec.funct3   = funct3;
    dec_entry.dec.funct7   = funct7;
    dec_entry.dec.fmt      = fmt;
    dec_entry.dec.illegal  = illegal;
    dec_entry.dec.rs1_used = !illegal && (opcode != OP_SYSTEM) &&
                             ((fmt == FMT_I) || (fmt == FMT_S) ||
                              (fmt == FMT_R) || (fmt == FMT_SB));
    dec_entry.dec.rs2_used = !illegal &&
                             ((fmt == FMT_S) || (fmt == FMT_R) || (fmt == FMT_SB));
    dec_entry.dec.rd_wr    = !illegal && (rd != 5'd0) &&
                             ((fmt == FMT_I) || (fmt == FMT_U) ||
                              (fmt == FMT_R) || (fmt == FMT_UJ));
  end

  occ_e   state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready;
  logic   accept;

  // With SKID=0 in_ready blocks whenever main is stalled, so OCC_BOTH is unreachable.
  assign in_ready = (SKID != 0) ? (state_q != OCC_BOTH)
                                : ((state_q == OCC_EMPTY) || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          main_d  = dec_entry;
          state_d = OCC_MAIN;
        end
      end
      OCC_MAIN: begin
        if (bus.out_ready) begin
          if (accept) main_d = dec_entry;
          else        state_d = OCC_EMPTY;
        end else if (accept) begin
          skid_d  = dec_entry;
          state_d = OCC_BOTH;
        end
      end
      OCC_BOTH: begin
        if (bus.out_ready) begin
          main_d  = skid_q;
          state_d = OCC_MAIN;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    // Flush wins over a same-cycle accept: the offered bundle is dropped.
    if (flush) state_d = OCC_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign dbg_state        = state_q;
  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = (state_q != OCC_EMPTY);
  assign bus.out_pc       = main_q.pc;
  assign bus.out_imm      = main_q.imm;
  assign bus.out_opcode   = main_q.dec.opcode;
  assign bus.out_rd       = main_q.dec.rd;
  assign bus.out_rs1      = main_q.dec.rs1;
  assign bus.out_rs2      = main_q.dec.rs2;
  assign bus.out_funct3   = main_q.dec.funct3;
  assign bus.out_funct7   = main_q.dec.funct7;
  assign bus.out_fmt      = main_q.dec.fmt;
  assign bus.out_rd_wr    = main_q.dec.rd_wr;
  assign bus.out_rs1_used = main_q.dec.rs1_used;
  assign bus.out_rs2_used = main_q.dec.rs2_used;
  assign bus.out_illegal  = main_q.dec.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: instance A (M_EXT=0, SKID=0) and B (M_EXT=1, SKID=1),
// directed decode checks plus a scoreboard that follows every accepted bundle.
module tb_rv_decode_stage;
  import rv_decode_pkg::*;

  localparam int W = 103;

  logic clk;
  logic rst_n;
  logic flush;
  occ_e dbg_a, dbg_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];

  rv_decode_if #(.XLEN(32)) bus_a ();
  rv_decode_if #(.XLEN(32)) bus_b ();

  rv_decode_stage #(.XLEN(32), .M_EXT(0), .SKID(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a.slave), .dbg_state(dbg_a)
  );

  rv_decode_stage #(.XLEN(32), .M_EXT(1), .SKID(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_b.slave), .dbg_state(dbg_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [31:0] i, input logic [31:0] pc,
                                         input bit mext);
    logic [2:0]  fmt;
    logic [31:0] imm;
    bit          ill, r1, r2, wr;
    ill = 1'b0;
    case (i[6:0])
      7'h03, 7'h13, 7'h73: fmt = 3'd0;
      7'h67: begin fmt = 3'd0; ill = (i[14:12] != 3'd0); end
      7'h1B: begin fmt = 3'd0; ill = 1'b1; end
      7'h17, 7'h37: fmt = 3'd1;
      7'h23: fmt = 3'd2;
      7'h33: fmt = 3'd3;
      7'h3B: begin fmt = 3'd3; ill = 1'b1; end
      7'h63: fmt = 3'd4;
      7'h6F: fmt = 3'd5;
      default: begin fmt = 3'd0; ill = 1'b1; end
    endcase
    if (fmt == 3'd3 && !(i[31:25] == 7'h00 || i[31:25] == 7'h20 ||
                         (mext && i[31:25] == 7'h01))) ill = 1'b1;
    case (fmt)
      3'd0: imm = {{20{i[31]}}, i[31:20]};
      3'd1: imm = {i[31:12], 12'h000};
      3'd2: imm = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd4: imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd5: imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
    r1 = !ill && (fmt == 3'd0 || fmt == 3'd2 || fmt == 3'd3 || fmt == 3'd4) && (i[6:0] != 7'h73);
    r2 = !ill && (fmt == 3'd2 || fmt == 3'd3 || fmt == 3'd4);
    wr = !ill && (fmt == 3'd0 || fmt == 3'd1 || fmt == 3'd3 || fmt == 3'd5) && (i[11:7] != 5'd0);
    return {pc, imm, i[6:0], i[11:7], i[19:15], i[24:20], i[14:12], i[31:25],
            fmt, wr, r1, r2, ill};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    logic [6:0]  f7;
    r = $urandom();
    case ($urandom_range(0, 13))
      0: op = 7'h03;  1: op = 7'h13;  2: op = 7'h17;  3: op = 7'h1B;
      4: op = 7'h23;  5: op = 7'h33;  6: op = 7'h37;  7: op = 7'h3B;
      8: op = 7'h63;  9: op = 7'h67; 10: op = 7'h6F; 11: op = 7'h73;
      12: op = 7'h0B;
      default: op = r[6:0];
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;  1: f7 = 7'h20;  2: f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:7], op};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] obs_a, obs_b;
  assign obs_a = {bus_a.out_pc, bus_a.out_imm, bus_a.out_opcode, bus_a.out_rd, bus_a.out_rs1,
                  bus_a.out_rs2, bus_a.out_funct3, bus_a.out_funct7, bus_a.out_fmt,
                  bus_a.out_rd_wr, bus_a.out_rs1_used, bus_a.out_rs2_used, bus_a.out_illegal};
  assign obs_b = {bus_b.out_pc, bus_b.out_imm, bus_b.out_opcode, bus_b.out_rd, bus_b.out_rs1,
                  bus_b.out_rs2, bus_b.out_funct3, bus_b.out_funct7, bus_b.out_fmt,
                  bus_b.out_rd_wr, bus_b.out_rs1_used, bus_b.out_rs2_used, bus_b.out_illegal};

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      if (bus_a.out_valid && bus_a.out_ready) begin
        n_cmp++;
        if (exp_q_a.size() == 0) begin
          n_bad++;
          $display("FAIL sb_a: unexpected bundle got=%h required=none", obs_a);
        end else begin
          e = exp_q_a.pop_front();
          if (obs_a !== e) begin
            n_bad++;
            $display("FAIL sb_a: got=%h required=%h", obs_a, e);
          end
        end
      end
      if (bus_b.out_valid && bus_b.out_ready) begin
        n_cmp++;
        if (exp_q_b.size() == 0) begin
          n_bad++;
          $display("FAIL sb_b: unexpected bundle got=%h required=none", obs_b);
        end else begin
          e = exp_q_b.pop_front();
          if (obs_b !== e) begin
            n_bad++;
            $display("FAIL sb_b: got=%h required=%h", obs_b, e);
          end
        end
      end
      if (flush) begin
        exp_q_a.delete();
        exp_q_b.delete();
      end else begin
        if (bus_a.in_valid && bus_a.in_ready) exp_q_a.push_back(model(bus_a.in_instr, bus_a.in_pc, 1'b0));
        if (bus_b.in_valid && bus_b.in_ready) exp_q_b.push_back(model(bus_b.in_instr, bus_b.in_pc, 1'b1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus_a.in_valid = 1'b0; bus_a.in_instr = 32'h0; bus_a.in_pc = 32'h0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_instr = 32'h0; bus_b.in_pc = 32'h0; bus_b.out_ready = 1'b1;
    flush = 1'b0;
  endtask

  task automatic offer_both(input logic [31:0] instr, input logic [31:0] pc);
    bus_a.in_valid = 1'b1; bus_a.in_instr = instr; bus_a.in_pc = pc;
    bus_b.in_valid = 1'b1; bus_b.in_instr = instr; bus_b.in_pc = pc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got a=%b b=%b required 0", bus_a.out_valid, bus_b.out_valid);
    end
    n_cmp++;
    if (obs_a !== '0 || obs_b !== '0) begin
      n_bad++; $display("FAIL reset_data: got a=%h b=%h required 0", obs_a, obs_b);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus_a.in_ready !== 1'b1 || bus_b.in_ready !== 1'b1 || dbg_b !== OCC_EMPTY) begin
      n_bad++; $display("FAIL reset_in_ready: got a=%b b=%b state=%0d required 1 1 0",
                        bus_a.in_ready, bus_b.in_ready, dbg_b);
    end
    next_cycle();
  endtask

  task automatic test_decode();
    logic [31:0] t_instr [0:9];
    logic [2:0]  t_fmt   [0:9];
    logic [31:0] t_imm   [0:9];
    logic        t_ill_a [0:9];
    logic        t_ill_b [0:9];
    logic        t_wr_a  [0:9];
    logic        t_wr_b  [0:9];
    t_instr[0] = 32'hFFF10093; t_fmt[0] = 3'd0; t_imm[0] = 32'hFFFFFFFF; t_ill_a[0] = 0; t_ill_b[0] = 0; t_wr_a[0] = 1; t_wr_b[0] = 1;
    t_instr[1] = 32'h123452B7; t_fmt[1] = 3'd1; t_imm[1] = 32'h12345000; t_ill_a[1] = 0; t_ill_b[1] = 0; t_wr_a[1] = 1; t_wr_b[1] = 1;
    t_instr[2] = 32'hFE000EE3; t_fmt[2] = 3'd4; t_imm[2] = 32'hFFFFFFFC; t_ill_a[2] = 0; t_ill_b[2] = 0; t_wr_a[2] = 0; t_wr_b[2] = 0;
    t_instr[3] = 32'h008000EF; t_fmt[3] = 3'd5; t_imm[3] = 32'h00000008; t_ill_a[3] = 0; t_ill_b[3] = 0; t_wr_a[3] = 1; t_wr_b[3] = 1;
    t_instr[4] = 32'h02208033; t_fmt[4] = 3'd3; t_imm[4] = 32'h00000000; t_ill_a[4] = 1; t_ill_b[4] = 0; t_wr_a[4] = 0; t_wr_b[4] = 0;
    t_instr[5] = 32'h0000001B; t_fmt[5] = 3'd0; t_imm[5] = 32'h00000000; t_ill_a[5] = 1; t_ill_b[5] = 1; t_wr_a[5] = 0; t_wr_b[5] = 0;
    t_instr[6] = 32'h00112623; t_fmt[6] = 3'd2; t_imm[6] = 32'h0000000C; t_ill_a[6] = 0; t_ill_b[6] = 0; t_wr_a[6] = 0; t_wr_b[6] = 0;
    t_instr[7] = 32'h000010E7; t_fmt[7] = 3'd0; t_imm[7] = 32'h00000000; t_ill_a[7] = 1; t_ill_b[7] = 1; t_wr_a[7] = 0; t_wr_b[7] = 0;
    t_instr[8] = 32'h00000010; t_fmt[8] = 3'd0; t_imm[8] = 32'h00000000; t_ill_a[8] = 1; t_ill_b[8] = 1; t_wr_a[8] = 0; t_wr_b[8] = 0;
    t_instr[9] = 32'h40208133; t_fmt[9] = 3'd3; t_imm[9] = 32'h00000000; t_ill_a[9] = 0; t_ill_b[9] = 0; t_wr_a[9] = 1; t_wr_b[9] = 1;
    for (int k = 0; k < 10; k++) begin
      logic [31:0] ins;
      ins = t_instr[k];
      offer_both(ins, 32'h1000 + 32'(4 * k));
      next_cycle();
      bus_a.in_valid = 1'b0;
      bus_b.in_valid = 1'b0;
      n_cmp++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_fmt !== t_fmt[k] || bus_a.out_imm !== t_imm[k]) begin
        n_bad++; $display("FAIL dec_a[%0d]: got v=%b fmt=%0d imm=%h required v=1 fmt=%0d imm=%h",
                          k, bus_a.out_valid, bus_a.out_fmt, bus_a.out_imm, t_fmt[k], t_imm[k]);
      end
      n_cmp++;
      if (bus_a.out_illegal !== t_ill_a[k] || bus_a.out_rd_wr !== t_wr_a[k] ||
          bus_a.out_rd !== ins[11:7] || bus_a.out_rs1 !== ins[19:15]) begin
        n_bad++; $display("FAIL flags_a[%0d]: got ill=%b wr=%b rd=%0d rs1=%0d required ill=%b wr=%b rd=%0d rs1=%0d",
                          k, bus_a.out_illegal, bus_a.out_rd_wr, bus_a.out_rd, bus_a.out_rs1,
                          t_ill_a[k], t_wr_a[k], ins[11:7], ins[19:15]);
      end
      n_cmp++;
      if (bus_b.out_valid !== 1'b1 || bus_b.out_illegal !== t_ill_b[k] || bus_b.out_rd_wr !== t_wr_b[k]) begin
        n_bad++; $display("FAIL flags_b[%0d]: got v=%b ill=%b wr=%b required v=1 ill=%b wr=%b",
                          k, bus_b.out_valid, bus_b.out_illegal, bus_b.out_rd_wr, t_ill_b[k], t_wr_b[k]);
      end
    end
    n_cmp++;
    if (bus_a.out_rs2_used !== 1'b1 || bus_b.out_rs1_used !== 1'b1) begin
      n_bad++; $display("FAIL sub_use: got rs2a=%b rs1b=%b required 1 1", bus_a.out_rs2_used, bus_b.out_rs1_used);
    end
    next_cycle();
  endtask

  task automatic test_skid();
    logic [31:0] s_instr [0:2];
    for (int k = 0; k < 3; k++) s_instr[k] = rand_instr();
    bus_a.in_valid  = 1'b0;
    bus_b.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus_b.in_valid = 1'b1; bus_b.in_instr = s_instr[k]; bus_b.in_pc = 32'h2000 + 32'(4 * k);
      #1;
      n_cmp++;
      if (bus_b.in_ready !== 1'b1) begin
        n_bad++; $display("FAIL skid_accept[%0d]: got in_ready=%b required 1", k, bus_b.in_ready);
      end
      next_cycle();
    end
    bus_b.in_instr = s_instr[2]; bus_b.in_pc = 32'h2008;
    #1;
    n_cmp++;
    if (bus_b.in_ready !== 1'b0 || dbg_b !== OCC_BOTH) begin
      n_bad++; $display("FAIL skid_full: got in_ready=%b state=%0d required 0 2", bus_b.in_ready, dbg_b);
    end
    repeat (2) next_cycle();
    n_cmp++;
    if (bus_b.out_pc !== 32'h2000 || bus_b.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL skid_hold: got pc=%h v=%b required 00002000 1", bus_b.out_pc, bus_b.out_valid);
    end
    bus_b.out_ready = 1'b1;
    next_cycle();
    n_cmp++;
    if (bus_b.out_pc !== 32'h2004 || bus_b.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL skid_move: got pc=%h rdy=%b required 00002004 1", bus_b.out_pc, bus_b.in_ready);
    end
    next_cycle();
    bus_b.in_valid = 1'b0;
    n_cmp++;
    if (bus_b.out_pc !== 32'h2008) begin
      n_bad++; $display("FAIL skid_third: got pc=%h required 00002008", bus_b.out_pc);
    end
    next_cycle();
    n_cmp++;
    if (bus_b.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL skid_drain: got v=%b required 0", bus_b.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      offer_both(rand_instr(), 32'h3000 + 32'(4 * k));
      #1;
      n_cmp++;
      if (bus_a.in_ready !== 1'b1 || bus_b.in_ready !== 1'b1) begin
        n_bad++; $display("FAIL b2b_ready[%0d]: got a=%b b=%b required 1 1", k, bus_a.in_ready, bus_b.in_ready);
      end
      if (k > 0) begin
        n_cmp++;
        if (bus_a.out_valid !== 1'b1 || bus_b.out_valid !== 1'b1 ||
            bus_b.out_pc !== 32'h3000 + 32'(4 * (k - 1))) begin
          n_bad++; $display("FAIL b2b_flow[%0d]: got va=%b vb=%b pc=%h required 1 1 %h",
                            k, bus_a.out_valid, bus_b.out_valid, bus_b.out_pc, 32'h3000 + 32'(4 * (k - 1)));
        end
      end
      next_cycle();
    end
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_flush();
    bus_a.out_ready = 1'b0;
    bus_b.out_ready = 1'b0;
    offer_both(32'h00500093, 32'h4000);
    next_cycle();
    offer_both(32'h00A00113, 32'h4004);
    flush = 1'b1;
    #1;
    n_cmp++;
    if (bus_a.in_ready !== 1'b0 || bus_b.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_ready: got a=%b b=%b required 0 1", bus_a.in_ready, bus_b.in_ready);
    end
    next_cycle();
    flush = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    n_cmp++;
    if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0 || dbg_b !== OCC_EMPTY) begin
      n_bad++; $display("FAIL flush_clear: got va=%b vb=%b state=%0d required 0 0 0",
                        bus_a.out_valid, bus_b.out_valid, dbg_b);
    end
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    repeat (3) next_cycle();
    n_cmp++;
    if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_drop: got va=%b vb=%b required 0 0", bus_a.out_valid, bus_b.out_valid);
    end
  endtask

  task automatic test_async_reset();
    bus_a.out_ready = 1'b0;
    bus_b.out_ready = 1'b0;
    offer_both(32'h123452B7, 32'h5000);
    next_cycle();
    offer_both(32'h008000EF, 32'h5004);
    next_cycle();
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0 || dbg_b !== OCC_EMPTY) begin
      n_bad++; $display("FAIL arst_valid: got va=%b vb=%b state=%0d required 0 0 0",
                        bus_a.out_valid, bus_b.out_valid, dbg_b);
    end
    n_cmp++;
    if (obs_a !== '0 || obs_b !== '0) begin
      n_bad++; $display("FAIL arst_data: got a=%h b=%h required 0", obs_a, obs_b);
    end
    exp_q_a.delete();
    exp_q_b.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus_a.in_ready !== 1'b1 || bus_b.in_ready !== 1'b1 || bus_b.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL arst_release: got ra=%b rb=%b vb=%b required 1 1 0",
                        bus_a.in_ready, bus_b.in_ready, bus_b.out_valid);
    end
    next_cycle();
  endtask

  task automatic test_random();
    bit acc_a, acc_b;
    acc_a = 1'b1;
    acc_b = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (!bus_a.in_valid || acc_a) begin
        bus_a.in_valid = ($urandom_range(0, 3) != 0);
        bus_a.in_instr = rand_instr();
        bus_a.in_pc    = $urandom();
      end
      if (!bus_b.in_valid || acc_b) begin
        bus_b.in_valid = ($urandom_range(0, 3) != 0);
        bus_b.in_instr = rand_instr();
        bus_b.in_pc    = $urandom();
      end
      bus_a.out_ready = ($urandom_range(0, 2) != 0);
      bus_b.out_ready = ($urandom_range(0, 2) != 0);
      #3;
      acc_a = bus_a.in_valid && bus_a.in_ready;
      acc_b = bus_b.in_valid && bus_b.in_ready;
      next_cycle();
    end
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
  endtask

  task automatic test_drain();
    int budget;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    budget = 0;
    while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && budget < 20) begin
      next_cycle();
      budget++;
    end
    next_cycle();
    n_cmp++;
    if (exp_q_a.size() != 0 || exp_q_b.size() != 0 || bus_a.out_valid !== 1'b0 || bus_b.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL drain: got left a=%0d b=%0d va=%b vb=%b required 0 0 0 0",
                        exp_q_a.size(), exp_q_b.size(), bus_a.out_valid, bus_b.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_skid();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered RISC-V (RV32I/RV64I base, optional M) decode stage.
- Accepts fetched instruction and PC over a valid/ready handshake.
- Splits the instruction into fields and classifies its format.
- Generates the sign-extended immediate, flags illegal encodings and drives a decoded bundle to the register-read/issue stage.
- Sits between fetch and issue. Supports pipeline flush and an optional skid buffer for a fully registered in_ready.

Parameters:
- XLEN, 32, datapath width for PC and immediate (32 or 64).
- M_EXT, 0, 1 = funct7 0x01 on OP/OP-32 is legal (MUL/DIV).
- SKID, 0, 0 = single register slice; 1 = two-entry skid buffer, in_ready depends on state only.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset.
- flush, input, 1, discard all held entries.
- in_valid, input, 1, fetch offers instruction.
- in_ready, output, 1, stage can accept.
- in_instr, input, 32, raw instruction.
- in_pc, input, XLEN, instruction address.
- out_valid, output, 1, decoded bundle valid.
- out_ready, input, 1, issue accepts bundle.
- out_pc, output, XLEN, PC of bundle.
- out_opcode, output, 7, instr[6:0].
- out_rd, output, 5, instr[11:7].
- out_rs1, output, 5, instr[19:15].
- out_rs2, output, 5, instr[24:20].
- out_funct3, output, 3, instr[14:12].
- out_funct7, output, 7, instr[31:25].
- out_fmt, output, 3, format code.
- out_imm, output, XLEN, sign-extended immediate.
- out_rd_wr, output, 1, instruction writes rd and rd != 0.
- out_rs1_used, output, 1, rs1 read.
- out_rs2_used, output, 1, rs2 read.
- out_illegal, output, 1, illegal encoding.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Format codes:
  - I=0: opcodes 0x03, 0x13, 0x1B, 0x67, 0x73.
  - U=1: 0x17, 0x37.
  - S=2: 0x23.
  - R=3: 0x33, 0x3B.
  - SB=4: 0x63.
  - UJ=5: 0x6F.
  - Any other opcode: fmt=I, illegal=1.
- Immediates, sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - SB: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - UJ: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R: imm = 0.
- Register-use flags:
  - rs1_used for I, S, R, SB, except when opcode=0x73.
  - rs2_used for S, R, SB.
  - rd_wr for I, U, R, UJ, and only when rd != 0.
- Illegal when any of:
  - instr[1:0] != 2'b11;
  - opcode unsupported;
  - R-type funct7 not in {0x00, 0x20}, plus 0x01 when M_EXT=1;
  - opcode 0x1B/0x3B with XLEN=32;
  - opcode 0x67 with funct3 != 0.
  - Illegal bundles still flow downstream, with rd_wr, rs1_used and rs2_used forced to 0.
- Latency: 1 cycle. A bundle accepted at edge N is visible at out_* after edge N.
- SKID=0:
  - in_ready = !out_valid || out_ready.
  - Accept loads the register.
  - Output held stable while out_valid && !out_ready.
- SKID=1:
  - Main plus skid register; in_ready = !skid_valid (registered).
  - If main is occupied and stalled, an incoming accept goes to skid.
  - When out_ready, skid moves to main.
  - Order is preserved; no bubble under continuous flow with out_ready=1.
- Simultaneous input and output handshakes in the same cycle: the new bundle replaces the departing one with no bubble.
- flush:
  - Synchronous; clears out_valid and skid_valid next edge.
  - Has priority over a same-cycle accept; the offered instruction is dropped.
  - in_ready is unaffected by flush in that cycle.
- Reset: out_valid=0, skid_valid=0, every out_* data field=0, in_ready=1 after reset.
- Reset asserted mid-stall discards all entries.
- Data registers need no reset beyond the zero requirement above.

Decomposition:
- Package rv_decode_pkg holds:
  - fmt_e enum (I, U, S, R, SB, UJ);
  - opcode localparams (OP_LOAD=0x03, OP_IMM=0x13, ...);
  - decoded bundle struct dec_bundle_t, parametrised by XLEN via typedef in the consumer.
- One combinational sub-module, rv_imm_gen (instr + fmt -> imm), reused later by the branch unit.
- Field and flag decode lives inline; the handshake/skid logic lives in the top.

Test Plan:
- 0xFFF10093 (addi x1,x2,-1) at XLEN=32 -> next cycle out_valid=1, fmt=0, rd=1, rs1=2, imm=0xFFFFFFFF, rd_wr=1, rs2_used=0, illegal=0.
- 0x123452B7 (lui x5), 0xFE000EE3 (beq x0,x0,-4), 0x008000EF (jal x1,8):
  - lui -> imm=0x12345000, fmt=1.
  - beq -> imm=0xFFFFFFFC, fmt=4, rd_wr=0.
  - jal -> imm=0x00000008, fmt=5.
- 0x02208033 (mul) with M_EXT=0 -> illegal=1, rd_wr=0; same instruction with M_EXT=1 -> illegal=0. Also 0x0000001B at XLEN=32 -> illegal=1.
- SKID=1, out_ready=0, three back-to-back offers:
  - first two accepted; in_ready=0 after the second;
  - release out_ready -> bundles emerge in order with no loss or duplication;
  - with out_ready held at 1, throughput is 1 per cycle.
- flush asserted while a bundle is stalled and in_valid=1 -> next cycle out_valid=0, skid empty, and the offered instruction never appears.
- rst_n pulsed low asynchronously mid-stall -> out_valid drops immediately, out_* data fields read 0, and in_ready=1 after release.
